// File: rtl/vx_lsu_serializer_pkg.sv
// vx_lsu_serializer_pkg
//   Shared definitions for the LSU serializer slice:
//   - memory opcode encodings carried on mem_read / mem_write
//   - FSM state type for the serializer
//   - access-size type and a helper that maps an opcode to its size
package vx_lsu_serializer_pkg;

  // mem_read encodings
  localparam logic [2:0] LB          = 3'd0;
  localparam logic [2:0] LH          = 3'd1;
  localparam logic [2:0] LW          = 3'd2;
  localparam logic [2:0] LBU         = 3'd4;
  localparam logic [2:0] LHU         = 3'd5;
  localparam logic [2:0] NO_MEM_READ = 3'd7;

  // mem_write encodings
  localparam logic [2:0] SB           = 3'd0;
  localparam logic [2:0] SH           = 3'd1;
  localparam logic [2:0] SW           = 3'd2;
  localparam logic [2:0] NO_MEM_WRITE = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Low two opcode bits encode the size for both loads and stores
  // (LBU/LHU share the size bits of LB/LH).
  function automatic acc_size_e access_size(input logic [1:0] code);
    case (code)
      2'd0:    return SZ_BYTE;
      2'd1:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/vx_lsu_align.sv
// vx_lsu_align
//   Combinational lane/byte alignment for the 32-bit data port.
//   Store side: byte enables and replicated write data.
//   Load side : shift the response word down to the addressed byte/half
//               and sign- or zero-extend it.
// Ports
//   i_size       access size (acc_size_e encoding)
//   i_mem_read   load opcode, selects extension
//   i_addr_lo    address bits [1:0]
//   i_store_data store data of the served lane
//   i_rsp_data   read word from memory
//   o_be         byte enables
//   o_wdata      lane-aligned write data
//   o_load_data  extracted/extended load result
module vx_lsu_align
  import vx_lsu_serializer_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [2:0]  i_mem_read,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rsp_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  acc_size_e   w_size;
  logic [1:0]  w_off;
  logic [31:0] w_word;

  always_comb begin
    w_size  = acc_size_e'(i_size);
    w_off   = '0;
    o_be    = '0;
    o_wdata = '0;
    case (w_size)
      SZ_BYTE: begin
        w_off   = i_addr_lo;
        o_be    = 4'b0001 << w_off;
        o_wdata = {4{i_store_data[7:0]}};
      end
      SZ_HALF: begin
        // addr[0] is ignored for halfwords; no misalignment trap
        w_off   = {i_addr_lo[1], 1'b0};
        o_be    = 4'b0011 << w_off;
        o_wdata = {2{i_store_data[15:0]}};
      end
      default: begin
        w_off   = 2'b00;
        o_be    = 4'b1111;
        o_wdata = i_store_data;
      end
    endcase
  end

  always_comb begin
    w_word = i_rsp_data >> {w_off, 3'b000};
    case (i_mem_read)
      LB:      o_load_data = {{24{w_word[7]}}, w_word[7:0]};
      LH:      o_load_data = {{16{w_word[15]}}, w_word[15:0]};
      LBU:     o_load_data = {24'b0, w_word[7:0]};
      LHU:     o_load_data = {16'b0, w_word[15:0]};
      default: o_load_data = w_word;
    endcase
  end

endmodule

// File: rtl/vx_lsu_serializer.sv
// vx_lsu_serializer
//   Memory stage after execute. Serializes the active threads of one warp
//   instruction onto a single 32-bit data-memory port (lowest lane first),
//   collects per-lane load results, then emits one write-back beat.
//   Non-memory instructions pass their ALU results through in one cycle.
// Ports
//   clk, reset                 clock, async active-high reset
//   in_*                       instruction from execute (taken when idle)
//   out_stall                  upstream hold (busy whenever not idle)
//   dmem_req_* / dmem_addr /
//   dmem_we / dmem_be /
//   dmem_wdata                 request channel (valid/ready)
//   dmem_rsp_valid/_data       response or store ack
//   out_wb_valid               single-cycle write-back beat
//   out_thread_mask .. out_PC_next  registered copies of the instruction
//   out_result                 per-lane load data, else ALU results
module vx_lsu_serializer
  import vx_lsu_serializer_pkg::*;
#(
  parameter  int NT = 4,
  parameter  int NW = 8,
  localparam int WW = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [NT-1:0]      in_thread_mask,
  input  logic [WW-1:0]      in_warp_num,
  input  logic [4:0]         in_rd,
  input  logic [1:0]         in_wb,
  input  logic [2:0]         in_mem_read,
  input  logic [2:0]         in_mem_write,
  input  logic [NT*32-1:0]   in_addr,
  input  logic [NT*32-1:0]   in_store_data,
  input  logic [NT*32-1:0]   in_alu_result,
  input  logic [31:0]        in_PC_next,
  output logic               out_stall,
  output logic               dmem_req_valid,
  input  logic               dmem_req_ready,
  output logic [31:0]        dmem_addr,
  output logic               dmem_we,
  output logic [3:0]         dmem_be,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_rsp_valid,
  input  logic [31:0]        dmem_rsp_data,
  output logic               out_wb_valid,
  output logic [NT-1:0]      out_thread_mask,
  output logic [WW-1:0]      out_warp_num,
  output logic [4:0]         out_rd,
  output logic [1:0]         out_wb,
  output logic [31:0]        out_PC_next,
  output logic [NT*32-1:0]   out_result
);

  localparam int LANE_W = (NT > 1) ? $clog2(NT) : 1;

  lsu_state_e r_state;
  lsu_state_e w_next;

  logic [NT-1:0]     r_pending;
  logic              r_is_store;
  logic [2:0]        r_mem_read;
  logic [1:0]        r_size;
  logic [31:0]       r_addr       [NT];
  logic [31:0]       r_store_data [NT];
  logic [31:0]       r_result     [NT];

  logic              w_accept;
  logic              w_is_mem;
  logic              w_is_store;
  logic              w_load_path;
  logic [1:0]        w_size;

  logic [LANE_W-1:0] w_lane;
  logic [NT-1:0]     w_lane_oh;
  logic              w_found;
  logic [NT-1:0]     w_pending_clr;
  logic [31:0]       w_lane_addr;
  logic [31:0]       w_lane_data;

  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load_data;

  // ---------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------
  always_comb begin
    w_accept    = in_valid && (r_state == ST_IDLE);
    w_is_mem    = (in_mem_read != NO_MEM_READ) || (in_mem_write != NO_MEM_WRITE);
    // Both fields set means store; the read field is then ignored.
    w_is_store  = (in_mem_write != NO_MEM_WRITE);
    w_load_path = w_is_mem && !w_is_store && (|in_thread_mask);
    w_size      = w_is_store ? access_size(in_mem_write[1:0])
                             : access_size(in_mem_read[1:0]);
  end

  // ---------------------------------------------------------------
  // Lane pointer: lowest set bit of the pending mask
  // ---------------------------------------------------------------
  always_comb begin
    w_lane    = '0;
    w_lane_oh = '0;
    w_found   = 1'b0;
    for (int unsigned i = 0; i < NT; i++) begin
      if (r_pending[i] && !w_found) begin
        w_lane       = LANE_W'(i);
        w_lane_oh[i] = 1'b1;
        w_found      = 1'b1;
      end
    end
    w_pending_clr = r_pending & ~w_lane_oh;
    w_lane_addr   = r_addr[w_lane];
    w_lane_data   = r_store_data[w_lane];
  end

  vx_lsu_align u_align (
    .i_size       (r_size),
    .i_mem_read   (r_mem_read),
    .i_addr_lo    (w_lane_addr[1:0]),
    .i_store_data (w_lane_data),
    .i_rsp_data   (dmem_rsp_data),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  // ---------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_next = (w_is_mem && (|in_thread_mask)) ? ST_REQ : ST_DONE;
        end
      end
      ST_REQ: begin
        if (dmem_req_ready) begin
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dmem_rsp_valid) begin
          w_next = (w_pending_clr == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request fields are built from registers only and the lane pointer
  // cannot move until the response, so they stay stable while stalled.
  always_comb begin
    out_stall      = (r_state != ST_IDLE);
    out_wb_valid   = (r_state == ST_DONE);
    dmem_req_valid = (r_state == ST_REQ);
    dmem_addr      = '0;
    dmem_we        = 1'b0;
    dmem_be        = '0;
    dmem_wdata     = '0;
    if (r_state == ST_REQ) begin
      dmem_addr  = {w_lane_addr[31:2], 2'b00};
      dmem_we    = r_is_store;
      dmem_be    = w_be;
      dmem_wdata = r_is_store ? w_wdata : '0;
    end
  end

  // ---------------------------------------------------------------
  // Instruction latch and result registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending       <= '0;
      r_is_store      <= 1'b0;
      r_mem_read      <= '0;
      r_size          <= '0;
      out_thread_mask <= '0;
      out_warp_num    <= '0;
      out_rd          <= '0;
      out_wb          <= '0;
      out_PC_next     <= '0;
      for (int unsigned i = 0; i < NT; i++) begin
        r_addr[i]       <= '0;
        r_store_data[i] <= '0;
        r_result[i]     <= '0;
      end
    end else if (w_accept) begin
      r_pending       <= w_is_mem ? in_thread_mask : '0;
      r_is_store      <= w_is_store;
      r_mem_read      <= in_mem_read;
      r_size          <= w_size;
      out_thread_mask <= in_thread_mask;
      out_warp_num    <= in_warp_num;
      out_rd          <= in_rd;
      out_wb          <= in_wb;
      out_PC_next     <= in_PC_next;
      for (int unsigned i = 0; i < NT; i++) begin
        r_addr[i]       <= in_addr[32*i +: 32];
        r_store_data[i] <= in_store_data[32*i +: 32];
        // Loads start from zero so inactive lanes report 0.
        r_result[i]     <= w_load_path ? '0 : in_alu_result[32*i +: 32];
      end
    end else if ((r_state == ST_WAIT) && dmem_rsp_valid) begin
      r_pending <= w_pending_clr;
      if (!r_is_store) begin
        r_result[w_lane] <= w_load_data;
      end
    end
  end

  always_comb begin
    out_result = '0;
    for (int unsigned i = 0; i < NT; i++) begin
      out_result[32*i +: 32] = r_result[i];
    end
  end

endmodule

// File: tb/tb_vx_lsu_serializer.sv
module tb_vx_lsu_serializer;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [3:0]   in_thread_mask;
  logic [2:0]   in_warp_num;
  logic [4:0]   in_rd;
  logic [1:0]   in_wb;
  logic [2:0]   in_mem_read;
  logic [2:0]   in_mem_write;
  logic [127:0] in_addr;
  logic [127:0] in_store_data;
  logic [127:0] in_alu_result;
  logic [31:0]  in_PC_next;
  logic         out_stall;
  logic         dmem_req_valid;
  logic         dmem_req_ready;
  logic [31:0]  dmem_addr;
  logic         dmem_we;
  logic [3:0]   dmem_be;
  logic [31:0]  dmem_wdata;
  logic         dmem_rsp_valid;
  logic [31:0]  dmem_rsp_data;
  logic         out_wb_valid;
  logic [3:0]   out_thread_mask;
  logic [2:0]   out_warp_num;
  logic [4:0]   out_rd;
  logic [1:0]   out_wb;
  logic [31:0]  out_PC_next;
  logic [127:0] out_result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vx_lsu_serializer #(.NT(4), .NW(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_thread_mask  (in_thread_mask),
    .in_warp_num     (in_warp_num),
    .in_rd           (in_rd),
    .in_wb           (in_wb),
    .in_mem_read     (in_mem_read),
    .in_mem_write    (in_mem_write),
    .in_addr         (in_addr),
    .in_store_data   (in_store_data),
    .in_alu_result   (in_alu_result),
    .in_PC_next      (in_PC_next),
    .out_stall       (out_stall),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_addr       (dmem_addr),
    .dmem_we         (dmem_we),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_rsp_valid  (dmem_rsp_valid),
    .dmem_rsp_data   (dmem_rsp_data),
    .out_wb_valid    (out_wb_valid),
    .out_thread_mask (out_thread_mask),
    .out_warp_num    (out_warp_num),
    .out_rd          (out_rd),
    .out_wb          (out_wb),
    .out_PC_next     (out_PC_next),
    .out_result      (out_result)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference load: pick the addressed byte/half by arithmetic, then extend.
  function automatic logic [31:0] load_ref(input logic [2:0] mr, input logic [31:0] a,
                                           input logic [31:0] rsp);
    logic [31:0] off;
    logic [31:0] v;
    off = a & 32'd3;
    case (mr)
      3'd0: begin v = (rsp >> (8 * off)) & 32'hFF;  return (v >= 32'd128)   ? v - 32'd256   : v; end
      3'd4: begin v = (rsp >> (8 * off)) & 32'hFF;  return v; end
      3'd1: begin v = (rsp >> (8 * (off & 32'd2))) & 32'hFFFF; return (v >= 32'd32768) ? v - 32'd65536 : v; end
      3'd5: begin v = (rsp >> (8 * (off & 32'd2))) & 32'hFFFF; return v; end
      default: return rsp;
    endcase
  endfunction

  function automatic logic [3:0] be_ref(input logic [2:0] mw, input logic [31:0] a);
    case (mw)
      3'd0:    return 4'd1 << (a & 32'd3);
      3'd1:    return 4'd3 << (a & 32'd2);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] wd_ref(input logic [2:0] mw, input logic [31:0] d);
    case (mw)
      3'd0:    return (d & 32'hFF) * 32'h0101_0101;
      3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  task automatic check_zero(input string pfx);
    chk({pfx, "_stall"},     out_stall, 0);
    chk({pfx, "_req_valid"}, dmem_req_valid, 0);
    chk({pfx, "_addr"},      dmem_addr, 0);
    chk({pfx, "_we"},        dmem_we, 0);
    chk({pfx, "_be"},        dmem_be, 0);
    chk({pfx, "_wdata"},     dmem_wdata, 0);
    chk({pfx, "_wb_valid"},  out_wb_valid, 0);
    chk({pfx, "_mask"},      out_thread_mask, 0);
    chk({pfx, "_warp"},      out_warp_num, 0);
    chk({pfx, "_rd"},        out_rd, 0);
    chk({pfx, "_wb"},        out_wb, 0);
    chk({pfx, "_pc"},        out_PC_next, 0);
    chk({pfx, "_result"},    out_result, 0);
  endtask

  // Issues one instruction (entered at posedge+1 with DUT idle), plays the
  // memory side with the given ready/response delays, and checks every
  // request and the write-back beat against the reference.
  task automatic run_op(input logic [2:0] mr, input logic [2:0] mw, input logic [3:0] mask,
                        input logic [127:0] addr_v, input logic [127:0] data_v,
                        input logic [127:0] alu_v, input int rdly, input int sdly,
                        input bit use_fixed, input logic [31:0] frsp);
    logic [31:0]  exp_res [4];
    logic [127:0] exp_pk;
    logic [2:0]   wp;
    logic [4:0]   rdv;
    logic [1:0]   wbv;
    logic [31:0]  pc;
    logic [31:0]  a;
    logic [31:0]  d;
    logic [31:0]  rsp;
    int           lanes[$];
    bit           is_mem, is_store, waiting, done;
    int           k, idx, hold, rcnt, lane, exp_lat;

    wp  = 3'($urandom_range(0, 7));
    rdv = 5'($urandom_range(0, 31));
    wbv = 2'($urandom_range(0, 3));
    pc  = $urandom();
    is_mem   = (mr != 3'd7) || (mw != 3'd7);
    is_store = (mw != 3'd7);
    for (int i = 0; i < 4; i++) if (mask[i]) lanes.push_back(i);
    k = is_mem ? lanes.size() : 0;
    for (int i = 0; i < 4; i++)
      exp_res[i] = (is_mem && !is_store && k > 0) ? 32'h0 : alu_v[32*i +: 32];
    exp_lat = 1 + 2 * k;

    chk("idle_before_issue", out_stall, 0);
    in_valid       = 1'b1;
    in_thread_mask = mask;
    in_warp_num    = wp;
    in_rd          = rdv;
    in_wb          = wbv;
    in_mem_read    = mr;
    in_mem_write   = mw;
    in_addr        = addr_v;
    in_store_data  = data_v;
    in_alu_result  = alu_v;
    in_PC_next     = pc;

    idx = 0; hold = 0; rcnt = 0; waiting = 0; done = 0;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      @(posedge clk); #1;
      in_valid       = 1'b0;
      dmem_rsp_valid = 1'b0;
      dmem_req_ready = 1'b0;
      chk("stall_busy", out_stall, 1);
      if (out_wb_valid) begin
        done = 1;
        chk("requests_served", idx, k);
        if (rdly == 0 && sdly == 1) chk("wb_latency", cyc, exp_lat);
        for (int i = 0; i < 4; i++) exp_pk[32*i +: 32] = exp_res[i];
        chk("wb_result", out_result, exp_pk);
        chk("wb_mask", out_thread_mask, mask);
        chk("wb_warp", out_warp_num, wp);
        chk("wb_rd", out_rd, rdv);
        chk("wb_wb", out_wb, wbv);
        chk("wb_pc", out_PC_next, pc);
      end else if (waiting) begin
        chk("no_req_in_wait", dmem_req_valid, 0);
        rcnt++;
        if (rcnt >= sdly) begin
          rsp = use_fixed ? frsp : $urandom();
          dmem_rsp_data  = rsp;
          dmem_rsp_valid = 1'b1;
          lane = lanes[idx];
          if (!is_store) exp_res[lane] = load_ref(mr, addr_v[32*lane +: 32], rsp);
          idx++;
          waiting = 0;
        end
      end else if (dmem_req_valid) begin
        if (idx >= k) begin
          chk("unexpected_req", dmem_req_valid, 0);
        end else begin
          lane = lanes[idx];
          a = addr_v[32*lane +: 32];
          d = data_v[32*lane +: 32];
          chk("req_addr", dmem_addr, a & 32'hFFFF_FFFC);
          chk("req_we", dmem_we, is_store);
          if (is_store) begin
            chk("req_be", dmem_be, be_ref(mw, a));
            chk("req_wdata", dmem_wdata, wd_ref(mw, d));
          end
          if (hold >= rdly) begin
            dmem_req_ready = 1'b1;
            waiting = 1; rcnt = 0; hold = 0;
          end else begin
            hold++;
            // stray response while a request is outstanding-but-unaccepted
            dmem_rsp_valid = 1'b1;
            dmem_rsp_data  = $urandom();
          end
        end
      end
    end
    if (!done) chk("wb_timeout", out_wb_valid, 1);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    chk("idle_after_wb", out_stall, 0);
    chk("wb_one_cycle", out_wb_valid, 0);
  endtask

  logic [2:0]   rmr, rmw;
  logic [127:0] ra, rdat, ralu;
  int           kind, tmp;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_thread_mask = '0; in_warp_num = '0; in_rd = '0; in_wb = '0;
    in_mem_read = 3'd7; in_mem_write = 3'd7;
    in_addr = '0; in_store_data = '0; in_alu_result = '0; in_PC_next = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Non-memory op
    ralu = {$urandom(), $urandom(), $urandom(), 32'h1234_5678};
    run_op(3'd7, 3'd7, 4'b0001, '0, '0, ralu, 0, 1, 0, '0);
    chk("nonmem_lane0", out_result[31:0], 32'h1234_5678);

    // LW over lanes 0,1,3
    run_op(3'd2, 3'd7, 4'b1011, {32'h10C, 32'h0, 32'h104, 32'h100}, '0,
           {4{32'hDEAD_0000}}, 0, 1, 0, '0);
    chk("lw_lane2_zero", out_result[95:64], 32'h0);

    // LB / LBU at byte 3
    run_op(3'd0, 3'd7, 4'b0001, {96'h0, 32'h203}, '0, '0, 0, 1, 1, 32'h80FF_EEDD);
    chk("lb_direct", out_result[31:0], 32'hFFFF_FF80);
    run_op(3'd4, 3'd7, 4'b0001, {96'h0, 32'h203}, '0, '0, 0, 1, 1, 32'h80FF_EEDD);
    chk("lbu_direct", out_result[31:0], 32'h0000_0080);

    // SH upper half, slow ack
    run_op(3'd7, 3'd1, 4'b0001, {96'h0, 32'h302}, {96'h0, 32'hAAAA_BEEF},
           {96'h0, 32'h5555_0001}, 0, 3, 0, '0);

    // SB with ready held low for 5 cycles
    run_op(3'd7, 3'd0, 4'b0100, {32'h0, 32'h0000_0501, 64'h0}, {32'h0, 32'h0000_00C3, 64'h0},
           {4{32'h0BAD_F00D}}, 5, 1, 0, '0);

    // Memory op with empty mask behaves like a non-memory op
    run_op(3'd2, 3'd7, 4'b0000, {4{32'h700}}, '0, {4{32'hCAFE_BABE}}, 0, 1, 0, '0);

    // Both fields set: treated as a store
    run_op(3'd2, 3'd2, 4'b1111, {32'h80C, 32'h808, 32'h804, 32'h800},
           {$urandom(), $urandom(), $urandom(), $urandom()}, {4{32'h1111_2222}}, 0, 1, 0, '0);

    // Randomized mix
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      tmp  = $urandom_range(0, 4);
      rmr  = (kind == 1 || kind == 3) ? 3'((tmp < 3) ? tmp : tmp + 1) : 3'd7;
      rmw  = (kind >= 2) ? 3'($urandom_range(0, 2)) : 3'd7;
      ra   = {$urandom(), $urandom(), $urandom(), $urandom()};
      rdat = {$urandom(), $urandom(), $urandom(), $urandom()};
      ralu = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_op(rmr, rmw, 4'($urandom_range(0, 15)), ra, rdat, ralu,
             $urandom_range(0, 2), $urandom_range(1, 3), 0, '0);
    end

    // Reset while waiting for a response, then a late response
    in_valid = 1'b1; in_thread_mask = 4'b0001; in_mem_read = 3'd2; in_mem_write = 3'd7;
    in_addr = {96'h0, 32'h400}; in_alu_result = {4{32'h7777_7777}}; in_PC_next = 32'h44;
    in_warp_num = 3'd5; in_rd = 5'd9; in_wb = 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_req_valid", dmem_req_valid, 1);
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    chk("abort_in_wait", dmem_req_valid, 0);
    #2 reset = 1'b1;
    #1 check_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'h1357_9BDF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      dmem_rsp_valid = 1'b0;
      chk("late_rsp_no_wb", out_wb_valid, 0);
      chk("late_rsp_idle", out_stall, 0);
      chk("late_rsp_no_req", dmem_req_valid, 0);
    end
    chk("late_rsp_result", out_result, 0);

    // Normal operation after the abort
    run_op(3'd1, 3'd7, 4'b0110, {32'h0, 32'h0000_0903, 32'h0000_0A01, 32'h0},
           '0, '0, 0, 1, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
